// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.
// Ciphertext is registered and flagged by a one-cycle done pulse 11 edges after ld.
module aes_cipher (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic         done,
   output logic [127:0] text_out
);

   localparam int unsigned RW = 4;
   localparam logic [RW-1:0] LAST_ROUND = RW'(10);
   localparam logic [RW-1:0] FINISH     = RW'(11);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic [127:0]  st;
   logic [127:0]  rk;
   logic [127:0]  rk_next;
   logic [127:0]  round_out;
   logic [RW-1:0] rnd;
   logic          busy;

   logic [7:0]    sb [16];
   logic [7:0]    sr [16];
   logic [7:0]    mc [16];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [RW-1:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // One key-expansion step from the current round key
   always_comb begin
      logic [31:0] w0, w1, w2, w3, rot, t;
      w0  = rk[127:96];
      w1  = rk[95:64];
      w2  = rk[63:32];
      w3  = rk[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
            ^ {rcon(rnd), 24'h000000};
      w0  = w0 ^ t;
      w1  = w1 ^ w0;
      w2  = w2 ^ w1;
      w3  = w3 ^ w2;
      rk_next = {w0, w1, w2, w3};
   end

   // One cipher round: SubBytes, ShiftRows, MixColumns (skipped on round 10), AddRoundKey
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      for (int i = 0; i < 16; i++) begin
         sb[i] = SBOX[st[127-8*i -: 8]];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = sb[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      round_out = '0;
      for (int i = 0; i < 16; i++) begin
         round_out[127-8*i -: 8] = ((rnd == LAST_ROUND) ? sr[i] : mc[i]) ^ rk_next[127-8*i -: 8];
      end
   end

   // Load, round sequencing and result capture; a load always wins over the running op
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= '0;
         rk       <= '0;
         rnd      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         text_out <= '0;
      end else begin
         done <= 1'b0;
         if (busy && rnd == FINISH) begin
            text_out <= st;
            done     <= 1'b1;
         end
         if (ld) begin
            st   <= text_in ^ key;
            rk   <= key;
            rnd  <= RW'(1);
            busy <= 1'b1;
         end else if (busy) begin
            if (rnd == FINISH) begin
               busy <= 1'b0;
               rnd  <= '0;
            end else begin
               st  <= round_out;
               rk  <= rk_next;
               rnd <= rnd + RW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher: FIPS-197 vectors, restart, back-to-back and reset cases.
module tb_aes_cipher;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] S_KEY  = 128'hcafebabedeadbeefdeadbeef00000000;
   localparam logic [127:0] S_PT   = 128'hed601a47199a4bebf815da96db76bee8;

   logic         clk = 1'b0;
   logic         rst;
   logic         ld;
   logic [127:0] key;
   logic [127:0] text_in;
   logic         done;
   logic [127:0] text_out;

   int tests = 0;
   int fails = 0;

   aes_cipher dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .key      (key),
      .text_in  (text_in),
      .done     (done),
      .text_out (text_out)
   );

   always #5 clk = ~clk;

   // ---------------- reference AES-128 (GF arithmetic, no lookup tables) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m(tmp[31:24]), sbox_m(tmp[23:16]), sbox_m(tmp[15:8]), sbox_m(tmp[7:0])};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_m(s[r][(c+r)%4]);
         for (int c = 0; c < 4; c++) begin
            if (rd < 10) begin
               s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
               s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
         end
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- stimulus helpers (drive and wait only) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] k, input logic [127:0] p);
      key = k; text_in = p; ld = 1'b1;
      tick();
      ld = 1'b0;
   endtask

   // Edges counted after the load edge until done, -1 when the 30-edge budget expires
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; ld = 1'b0; key = '0; text_in = '0;
      tick(); tick();
      tests++;
      if (done !== 1'b0 || text_out !== 128'h0) begin
         fails++;
         $display("FAIL reset_hold: done=%b text_out=%h, required done=0 text_out=0", done, text_out);
      end
      rst = 1'b1;
      tick(); tick(); tick();
      tests++;
      if (done !== 1'b0 || text_out !== 128'h0) begin
         fails++;
         $display("FAIL reset_release: done=%b text_out=%h, required done=0 text_out=0", done, text_out);
      end
   endtask

   task automatic test_c1();
      int lat;
      load(C1_KEY, C1_PT);
      wait_done(lat);
      tests++;
      if (lat !== 11) begin
         fails++;
         $display("FAIL c1_latency: got %0d, required 11", lat);
      end
      tests++;
      if (text_out !== C1_CT) begin
         fails++;
         $display("FAIL c1_ct: got %h, required %h", text_out, C1_CT);
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL c1_done_pulse: done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_appb_idle();
      int lat;
      load(B_KEY, B_PT);
      wait_done(lat);
      tests++;
      if (lat !== 11 || text_out !== B_CT) begin
         fails++;
         $display("FAIL appb: lat=%0d ct=%h, required lat=11 ct=%h", lat, text_out, B_CT);
      end
      for (int n = 0; n < 20; n++) begin
         tick();
         tests++;
         if (done !== 1'b0 || text_out !== B_CT) begin
            fails++;
            $display("FAIL appb_idle[%0d]: done=%b ct=%h, required done=0 ct=%h", n, done, text_out, B_CT);
         end
      end
   endtask

   task automatic test_system_vector();
      int lat;
      logic [127:0] exp;
      exp = aes_model(S_KEY, S_PT);
      load(S_KEY, S_PT);
      wait_done(lat);
      tests++;
      if (lat !== 11) begin
         fails++;
         $display("FAIL sys_latency: got %0d, required 11", lat);
      end
      tests++;
      if (text_out !== exp) begin
         fails++;
         $display("FAIL sys_ct: got %h, required %h", text_out, exp);
      end
   endtask

   task automatic test_restart();
      int lat;
      load(B_KEY, B_PT);
      tick(); tick(); tick();
      load(C1_KEY, C1_PT);
      wait_done(lat);
      tests++;
      if (lat !== 11 || text_out !== C1_CT) begin
         fails++;
         $display("FAIL restart: lat=%0d ct=%h, required lat=11 ct=%h", lat, text_out, C1_CT);
      end
      for (int n = 0; n < 15; n++) begin
         tick();
         tests++;
         if (done !== 1'b0) begin
            fails++;
            $display("FAIL restart_extra_done[%0d]: done=%b, required 0", n, done);
         end
      end
   endtask

   task automatic test_ld_held();
      int lat;
      key = B_KEY; text_in = B_PT; ld = 1'b1;
      tick(); tick(); tick();
      ld = 1'b0;
      wait_done(lat);
      tests++;
      if (lat !== 11 || text_out !== B_CT) begin
         fails++;
         $display("FAIL ld_held: lat=%0d ct=%h, required lat=11 ct=%h", lat, text_out, B_CT);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      load(B_KEY, B_PT);
      for (int n = 1; n <= 10; n++) begin
         tick();
         tests++;
         if (done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_early_done[%0d]: done=%b, required 0", n, done);
         end
      end
      key = C1_KEY; text_in = C1_PT; ld = 1'b1;
      tick();
      ld = 1'b0;
      tests++;
      if (done !== 1'b1 || text_out !== B_CT) begin
         fails++;
         $display("FAIL b2b_first: done=%b ct=%h, required done=1 ct=%h", done, text_out, B_CT);
      end
      wait_done(lat);
      tests++;
      if (lat !== 11 || text_out !== C1_CT) begin
         fails++;
         $display("FAIL b2b_second: lat=%0d ct=%h, required lat=11 ct=%h", lat, text_out, C1_CT);
      end
   endtask

   task automatic test_async_reset();
      int lat;
      load(S_KEY, S_PT);
      tick(); tick(); tick(); tick(); tick();
      #2 rst = 1'b0;
      #1;
      tests++;
      if (done !== 1'b0 || text_out !== 128'h0) begin
         fails++;
         $display("FAIL async_reset: done=%b ct=%h, required done=0 ct=0", done, text_out);
      end
      tick();
      rst = 1'b1;
      for (int n = 0; n < 15; n++) begin
         tick();
         tests++;
         if (done !== 1'b0 || text_out !== 128'h0) begin
            fails++;
            $display("FAIL async_reset_after[%0d]: done=%b ct=%h, required done=0 ct=0", n, done, text_out);
         end
      end
      load(C1_KEY, C1_PT);
      wait_done(lat);
      tests++;
      if (lat !== 11 || text_out !== C1_CT) begin
         fails++;
         $display("FAIL async_reset_rerun: lat=%0d ct=%h, required lat=11 ct=%h", lat, text_out, C1_CT);
      end
   endtask

   initial begin
      test_reset();
      test_c1();
      test_appb_idle();
      test_system_vector();
      test_restart();
      test_ld_held();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
